// File: rtl/uc_pkg.sv
// Shared definitions for the UC command link: widths, FSM states and the
// command-to-chip-word encoder used by the transmitter and future receivers.
package uc_pkg;

  localparam int CMD_W    = 5;
  localparam int CMD_MAX  = 24;
  localparam int CHIP_N   = 12;
  localparam int VAL_W    = 6;
  localparam int SKIP_VAL = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } uc_state_e;

  // Value 13 is reserved on the line, so codes from 13 upward shift up by one.
  function automatic logic [CHIP_N-1:0] uc_encode(input logic [CMD_W-1:0] cmd);
    logic [VAL_W-1:0]  v;
    logic [CHIP_N-1:0] c;
    v = (cmd < CMD_W'(SKIP_VAL)) ? {1'b0, cmd} : ({1'b0, cmd} + 6'd1);
    c = {CHIP_N{1'b0}};
    for (int k = 0; k < VAL_W; k++) begin
      c[2*k +: 2] = v[k] ? 2'b10 : 2'b01;
    end
    return c;
  endfunction

endpackage

// File: rtl/uc_tick_gen.sv
// Line-tick divider: one-cycle strobe every TICK_DIV clocks, restartable by clr
// so frame timing can be aligned to the acceptance cycle.
module uc_tick_gen #(
  parameter int TICK_DIV = 69445
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear on request, wrap at the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == LAST) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Divider counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uc_tx.sv
// UC command-link transmitter: one frame per accepted command (preamble,
// 12 Manchester chips, low guard). Define UC_TX_REPEAT_EN to send every frame twice.
module uc_tx
  import uc_pkg::*;
#(
  parameter int TICK_DIV   = 69445,
  parameter int PRE_TICKS  = 13,
  parameter int CHIP_TICKS = 16,
  parameter int GAP_TICKS  = 208
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             cmd_err,
  output logic             tx,
  output logic             busy,
  output logic             tick
);

  localparam int MAX_PC = (PRE_TICKS > CHIP_TICKS) ? PRE_TICKS : CHIP_TICKS;
  localparam int MAX_T  = (GAP_TICKS > MAX_PC) ? GAP_TICKS : MAX_PC;
  localparam int TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam logic [TW-1:0] PRE_LAST  = TW'(PRE_TICKS - 1);
  localparam logic [TW-1:0] CHIP_LAST = TW'(CHIP_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
  localparam logic [3:0]    IDX_LAST  = 4'(CHIP_N - 1);

  uc_state_e         state_q, state_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [CHIP_N-1:0] chip_q, chip_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              clr_s;
  logic              tick_s;
`ifdef UC_TX_REPEAT_EN
  logic              rep_q, rep_d;
`endif

  uc_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  // Frame sequencer: acceptance in IDLE, then one step per line tick.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    idx_d   = idx_q;
    chip_d  = chip_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    err_d   = 1'b0;
    clr_s   = 1'b0;
`ifdef UC_TX_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d    = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (cmd_valid && ready_q) begin
          if (cmd <= CMD_W'(CMD_MAX)) begin
            chip_d  = uc_encode(cmd);
            state_d = PRE;
            tcnt_d  = {TW{1'b0}};
            idx_d   = 4'd0;
            tx_d    = 1'b1;
            busy_d  = 1'b1;
            ready_d = 1'b0;
            clr_s   = 1'b1;
`ifdef UC_TX_REPEAT_EN
            rep_d   = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end else begin
          err_d = 1'b0;
        end
      end
      PRE: begin
        if (tick_s) begin
          if (tcnt_q == PRE_LAST) begin
            state_d = DATA;
            tcnt_d  = {TW{1'b0}};
            idx_d   = 4'd0;
            tx_d    = chip_q[0];
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (tcnt_q == CHIP_LAST) begin
            tcnt_d = {TW{1'b0}};
            if (idx_q == IDX_LAST) begin
              state_d = GAP;
              tx_d    = 1'b0;
            end else begin
              idx_d = idx_q + 4'd1;
              tx_d  = chip_q[idx_q + 4'd1];
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      GAP: begin
        if (tick_s) begin
          if (tcnt_q == GAP_LAST) begin
            tcnt_d = {TW{1'b0}};
`ifdef UC_TX_REPEAT_EN
            if (!rep_q) begin
              rep_d   = 1'b1;
              state_d = PRE;
              tx_d    = 1'b1;
            end else begin
              rep_d   = 1'b0;
              state_d = IDLE;
              busy_d  = 1'b0;
              ready_d = 1'b1;
            end
`else
            state_d = IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
`endif
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        tcnt_d  = {TW{1'b0}};
        tx_d    = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset forces the line low immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tcnt_q  <= {TW{1'b0}};
      idx_q   <= 4'd0;
      chip_q  <= {CHIP_N{1'b0}};
      tx_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef UC_TX_REPEAT_EN
      rep_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      idx_q   <= idx_d;
      chip_q  <= chip_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      err_q   <= err_d;
`ifdef UC_TX_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign cmd_ready = ready_q;
  assign cmd_err   = err_q;
  assign tick      = tick_s;

endmodule
